ahb_matrix_decode_param: RTL and testbench
==========================================

Name: ahb_matrix_decode_param

Overview:
Parametrised AHB bus-matrix input-stage decoder. It routes one input stage to NUM_PORTS output stages using per-port base/mask regions, and it contains a default slave that gives a two-cycle ERROR response. It also has a boot remap input and a debug counter plus address capture for unmapped accesses. It replaces the per-configuration fixed-map decoders in the L1 AHB matrix.

Parameters:
NUM_PORTS, 3, number of output stages (1..15).
BASE_ADDR, {22'h0C0000,22'h040000,22'h000000}, packed region bases on HADDR[31:10]; port i is in [22*i+:22].
ADDR_MASK, {22'h3C0000,22'h3FFFC0,22'h3FFFF0}, packed region masks, same packing as BASE_ADDR.
REMAP_PORT, 1, port that takes over port 0's region while remap=1.
CNT_W, 16, width of the unmapped-access counter.

Ports:
HCLK  in  1  AHB clock
HRESETn  in  1  async active-low reset
HREADYS  in  1  input-stage HREADY
sel_dec  in  1  HSEL from input stage
decode_addr_dec  in  22  HADDR[31:10]
trans_dec  in  2  HTRANS
remap  in  1  boot remap enable, quasi-static
err_clr  in  1  synchronous clear of err_count/err_addr
active_in  in  NUM_PORTS  output-stage active flags
readyout_in  in  NUM_PORTS  output-stage HREADYOUT
resp_in  in  2*NUM_PORTS  output-stage HRESP, port i at [2*i+:2]
rdata_in  in  32*NUM_PORTS  HRDATA, port i at [32*i+:32]
ruser_in  in  32*NUM_PORTS  HRUSER, port i at [32*i+:32]
sel_out  out  NUM_PORTS  one-hot HSEL per output stage
active_dec  out  1  active flag of the addressed stage
HREADYOUTS  out  1  selected HREADYOUT
HRESPS  out  2  selected HRESP
HRDATAS  out  32  selected read data
HRUSERS  out  32  selected user data
err_count  out  CNT_W  saturating count of unmapped NONSEQ/SEQ transfers
err_addr  out  22  HADDR[31:10] of the most recent unmapped transfer

Behaviour:
- Clock is HCLK; reset is HRESETn, asynchronous, active-low.
- Port encoding: addr_port and data_port are clog2(NUM_PORTS+1) bits wide. Values 0..NUM_PORTS-1 are real ports; the value NUM_PORTS is the default slave (DFT).
- Match rule: port i matches when (addr & MASK_i) == (BASE_i & MASK_i). The lowest index wins if several ports match. No match selects DFT.
- Remap: when remap=1, a match on port 0 is routed to REMAP_PORT. All other ports are unaffected.
- Hold rule: if trans_dec==2'b00 and data_port!=DFT, then addr_port=data_port. This applies regardless of address.
- sel_out and active_dec are combinational:
  - sel_out[addr_port]=sel_dec when addr_port is a real port; otherwise all zero.
  - active_dec=active_in[addr_port], or 1 when addr_port is DFT.
- data_port register: loads addr_port when HREADYS=1; otherwise holds. Reset value is 0.
- Data-phase mux (combinational on data_port):
  - Real port: HREADYOUTS, HRESPS, HRDATAS and HRUSERS come from that port's inputs.
  - DFT: HRDATAS=0 and HRUSERS=0; HREADYOUTS and HRESPS come from the default-slave FSM.
- Default-slave FSM, states IDLE/ERR1/ERR2. Reset state is IDLE.
  - IDLE: ready=1, resp=00. Go to ERR1 if sel_dec & (addr_port==DFT) & HREADYS & trans_dec[1].
  - ERR1: ready=0, resp=01. Always go to ERR2.
  - ERR2: ready=1, resp=01. Go to ERR1 if the IDLE trigger holds this cycle, else go to IDLE.
  - IDLE or BUSY transfers to DFT get a zero-wait OKAY.
- Error capture: on each FSM trigger, err_count increments (saturating at all-ones) and err_addr loads decode_addr_dec.
  - err_clr=1 zeroes both.
  - err_clr and a trigger in the same cycle give err_count=1 and err_addr=the new address.
- Output reset values:
  - err_count=0, err_addr=0, FSM=IDLE.
  - data_port=0, so HREADYOUTS/HRESPS/HRDATAS/HRUSERS track port 0's inputs during reset.
  - sel_out and active_dec stay combinational.
- Reset asserted mid-ERR1: FSM goes to IDLE immediately and HREADYOUTS follows readyout_in[0].
- Latency: address-phase decode is 0 cycles; data-phase select is 1 cycle after HREADYS; an unmapped access completes with ERROR in 2 cycles.

Test Plan:
- Map check: addresses 0x00003C00, 0x1000FC00 and 0x30000000 each with NONSEQ -> sel_out=001, 010 and 100 respectively; the next data phase returns rdata_in for the same port.
- Unmapped: NONSEQ to 0x20000000 with HREADYS=1 -> sel_out=000, active_dec=1. Next cycle HREADYOUTS=0/HRESPS=01, then 1/01. err_count=1, err_addr=22'h080000.
- Back-to-back unmapped: NONSEQ unmapped, then a second NONSEQ unmapped issued in ERR2 -> FSM goes ERR2->ERR1 and err_count=2. With err_clr pulsed in the same cycle as that second trigger, err_count=1 instead.
- Remap: remap=1, NONSEQ to 0x00000400 -> sel_out=010. Remap=0 with the same address -> sel_out=001.
- Hold rule and stall: NONSEQ to port 1 with readyout_in[1]=0 for 3 cycles, then IDLE to 0x20000000 -> data_port stays 1 and HREADYOUTS follows readyout_in[1]. sel_out[1] stays asserted and err_count is unchanged.
- Reset mid-error and saturation: assert HRESETn=0 during ERR1 -> HREADYOUTS=readyout_in[0] at once and err_count=0. With CNT_W=2, four unmapped NONSEQ transfers -> err_count=3.

Source files
------------

// File: rtl/ahb_matrix_decode_param.sv
// AHB bus-matrix input-stage decoder: base/mask region match, boot remap, data-phase
// response mux and a two-cycle ERROR default slave with an unmapped-access log.
module ahb_matrix_decode_param #(
    parameter int                      NUM_PORTS  = 3,
    parameter logic [22*NUM_PORTS-1:0] BASE_ADDR  = {22'h0C0000, 22'h040000, 22'h000000},
    parameter logic [22*NUM_PORTS-1:0] ADDR_MASK  = {22'h3C0000, 22'h3FFFC0, 22'h3FFFF0},
    parameter int                      REMAP_PORT = 1,
    parameter int                      CNT_W      = 16
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      HREADYS,
    input  logic                      sel_dec,
    input  logic [21:0]               decode_addr_dec,
    input  logic [1:0]                trans_dec,
    input  logic                      remap,
    input  logic                      err_clr,
    input  logic [NUM_PORTS-1:0]      active_in,
    input  logic [NUM_PORTS-1:0]      readyout_in,
    input  logic [2*NUM_PORTS-1:0]    resp_in,
    input  logic [32*NUM_PORTS-1:0]   rdata_in,
    input  logic [32*NUM_PORTS-1:0]   ruser_in,
    output logic [NUM_PORTS-1:0]      sel_out,
    output logic                      active_dec,
    output logic                      HREADYOUTS,
    output logic [1:0]                HRESPS,
    output logic [31:0]               HRDATAS,
    output logic [31:0]               HRUSERS,
    output logic [CNT_W-1:0]          err_count,
    output logic [21:0]               err_addr
);

    localparam int             PW  = $clog2(NUM_PORTS + 1);
    localparam logic [PW-1:0]  DFT = PW'(NUM_PORTS);

    typedef enum logic [1:0] {IDLE, ERR1, ERR2} dft_state_t;

    dft_state_t              state_q, state_d;
    logic [PW-1:0]           data_port_q;
    logic [PW-1:0]           match_port;
    logic [PW-1:0]           addr_port;
    logic [NUM_PORTS-1:0]    match;
    logic                    trigger;
    logic                    dft_ready;
    logic [1:0]              dft_resp;
    logic [CNT_W-1:0]        err_count_q, err_count_d;
    logic [21:0]             err_addr_q, err_addr_d;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign match[gi]   = (decode_addr_dec & ADDR_MASK[22*gi +: 22])
                              == (BASE_ADDR[22*gi +: 22] & ADDR_MASK[22*gi +: 22]);
            assign sel_out[gi] = sel_dec && (addr_port == PW'(gi));
        end
    endgenerate

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        match_port = DFT;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (match[i]) match_port = PW'(i);
        end
        addr_port = match_port;
        if (remap && (match_port == '0)) addr_port = PW'(REMAP_PORT);
        if ((trans_dec == 2'b00) && (data_port_q != DFT)) addr_port = data_port_q;
    end

    always_comb begin
        active_dec = 1'b1;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (addr_port == PW'(i)) active_dec = active_in[i];
        end
    end

    assign trigger = sel_dec && (addr_port == DFT) && HREADYS && trans_dec[1];

    always_comb begin
        state_d   = state_q;
        dft_ready = 1'b1;
        dft_resp  = 2'b00;
        case (state_q)
            IDLE: if (trigger) state_d = ERR1;
            ERR1: begin
                dft_ready = 1'b0;
                dft_resp  = 2'b01;
                state_d   = ERR2;
            end
            ERR2: begin
                dft_resp = 2'b01;
                state_d  = trigger ? ERR1 : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        HREADYOUTS = dft_ready;
        HRESPS     = dft_resp;
        HRDATAS    = '0;
        HRUSERS    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (data_port_q == PW'(i)) begin
                HREADYOUTS = readyout_in[i];
                HRESPS     = resp_in[2*i +: 2];
                HRDATAS    = rdata_in[32*i +: 32];
                HRUSERS    = ruser_in[32*i +: 32];
            end
        end
    end

    // A trigger coinciding with a clear is logged as the first event after the clear.
    always_comb begin
        err_count_d = err_count_q;
        err_addr_d  = err_addr_q;
        if (err_clr) begin
            err_count_d = trigger ? CNT_W'(1) : '0;
            err_addr_d  = trigger ? decode_addr_dec : '0;
        end else if (trigger) begin
            err_count_d = (&err_count_q) ? err_count_q : err_count_q + CNT_W'(1);
            err_addr_d  = decode_addr_dec;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= IDLE;
            data_port_q <= '0;
            err_count_q <= '0;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            if (HREADYS) data_port_q <= addr_port;
            err_count_q <= err_count_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign err_count = err_count_q;
    assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_ahb_matrix_decode_param.sv
// Directed bench for ahb_matrix_decode_param; a second instance with a 2-bit counter
// shares the stimulus to observe counter saturation.
module tb_ahb_matrix_decode_param;

    localparam int NP = 3;

    logic              HCLK = 1'b0;
    logic              HRESETn;
    logic              HREADYS;
    logic              sel_dec;
    logic [21:0]       decode_addr_dec;
    logic [1:0]        trans_dec;
    logic              remap;
    logic              err_clr;
    logic [NP-1:0]     active_in;
    logic [NP-1:0]     readyout_in;
    logic [2*NP-1:0]   resp_in;
    logic [32*NP-1:0]  rdata_in;
    logic [32*NP-1:0]  ruser_in;

    logic [NP-1:0]     sel_out, sel_out_s;
    logic              active_dec, active_dec_s;
    logic              HREADYOUTS, HREADYOUTS_s;
    logic [1:0]        HRESPS, HRESPS_s;
    logic [31:0]       HRDATAS, HRDATAS_s;
    logic [31:0]       HRUSERS, HRUSERS_s;
    logic [15:0]       err_count;
    logic [1:0]        err_count_s;
    logic [21:0]       err_addr, err_addr_s;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_cnt;

    always #5 HCLK = ~HCLK;

    ahb_matrix_decode_param u_dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HREADYS(HREADYS), .sel_dec(sel_dec),
        .decode_addr_dec(decode_addr_dec), .trans_dec(trans_dec), .remap(remap),
        .err_clr(err_clr), .active_in(active_in), .readyout_in(readyout_in),
        .resp_in(resp_in), .rdata_in(rdata_in), .ruser_in(ruser_in),
        .sel_out(sel_out), .active_dec(active_dec), .HREADYOUTS(HREADYOUTS),
        .HRESPS(HRESPS), .HRDATAS(HRDATAS), .HRUSERS(HRUSERS),
        .err_count(err_count), .err_addr(err_addr)
    );

    ahb_matrix_decode_param #(.CNT_W(2)) u_dut_sat (
        .HCLK(HCLK), .HRESETn(HRESETn), .HREADYS(HREADYS), .sel_dec(sel_dec),
        .decode_addr_dec(decode_addr_dec), .trans_dec(trans_dec), .remap(remap),
        .err_clr(err_clr), .active_in(active_in), .readyout_in(readyout_in),
        .resp_in(resp_in), .rdata_in(rdata_in), .ruser_in(ruser_in),
        .sel_out(sel_out_s), .active_dec(active_dec_s), .HREADYOUTS(HREADYOUTS_s),
        .HRESPS(HRESPS_s), .HRDATAS(HRDATAS_s), .HRUSERS(HRUSERS_s),
        .err_count(err_count_s), .err_addr(err_addr_s)
    );

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Unmapped NONSEQ walked through ERR1 and ERR2; leaves the bus IDLE in ERR2.
    task automatic do_unmapped(input logic [21:0] a);
        sel_dec = 1'b1; trans_dec = 2'b10; HREADYS = 1'b1; decode_addr_dec = a;
        tick();
        trans_dec = 2'b00; HREADYS = 1'b0;
        tick();
        HREADYS = 1'b1;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0; HREADYS = 1'b1; sel_dec = 1'b0; decode_addr_dec = '0;
        trans_dec = 2'b00; remap = 1'b0; err_clr = 1'b0;
        active_in = 3'b101; readyout_in = 3'b110;
        resp_in  = {2'b00, 2'b01, 2'b00};
        rdata_in = {32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
        ruser_in = {32'hB000_0002, 32'hB000_0001, 32'hB000_0000};
        tick(); tick();
        checks++;
        if (HREADYOUTS !== 1'b0) begin errors++; $display("FAIL reset_ready0: got %b want 0", HREADYOUTS); end
        checks++;
        if (HRDATAS !== 32'hA000_0000) begin errors++; $display("FAIL reset_rdata: got %h want a0000000", HRDATAS); end
        checks++;
        if (err_count !== 16'd0 || err_addr !== 22'd0) begin errors++; $display("FAIL reset_err: got cnt %0d addr %h want 0/0", err_count, err_addr); end
        readyout_in = 3'b111;
        #1;
        checks++;
        if (HREADYOUTS !== 1'b1 || HRESPS !== 2'b00) begin errors++; $display("FAIL reset_track: got %b/%b want 1/00", HREADYOUTS, HRESPS); end
        HRESETn = 1'b1;
        tick();
        exp_cnt = 16'd0;
        $display("test_reset done");
    endtask

    task automatic test_map();
        logic [21:0] addrs [3];
        logic [2:0]  sels  [3];
        addrs[0] = 22'h00000F; addrs[1] = 22'h04003F; addrs[2] = 22'h0C0000;
        sels[0]  = 3'b001;     sels[1]  = 3'b010;     sels[2]  = 3'b100;
        for (int k = 0; k < 3; k++) begin
            sel_dec = 1'b1; trans_dec = 2'b10; HREADYS = 1'b1; decode_addr_dec = addrs[k];
            #1;
            checks++;
            if (sel_out !== sels[k]) begin errors++; $display("FAIL map_sel%0d: got %b want %b", k, sel_out, sels[k]); end
            checks++;
            if (active_dec !== active_in[k]) begin errors++; $display("FAIL map_active%0d: got %b want %b", k, active_dec, active_in[k]); end
            tick();
            trans_dec = 2'b00;
            #1;
            checks++;
            if (HRDATAS !== 32'hA000_0000 + k || HRUSERS !== 32'hB000_0000 + k) begin
                errors++; $display("FAIL map_data%0d: got %h/%h want port %0d data", k, HRDATAS, HRUSERS, k);
            end
            checks++;
            if (HRESPS !== ((k == 1) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL map_resp%0d: got %b", k, HRESPS); end
            tick();
            $display("test_map port %0d addr %h sel %b", k, addrs[k], sel_out);
        end
    endtask

    task automatic test_unmapped();
        sel_dec = 1'b1; trans_dec = 2'b10; HREADYS = 1'b1; decode_addr_dec = 22'h080000;
        #1;
        checks++;
        if (sel_out !== 3'b000 || active_dec !== 1'b1) begin errors++; $display("FAIL unm_addr: got sel %b act %b want 000/1", sel_out, active_dec); end
        tick();
        exp_cnt = exp_cnt + 16'd1;
        checks++;
        if (HREADYOUTS !== 1'b0 || HRESPS !== 2'b01) begin errors++; $display("FAIL unm_err1: got %b/%b want 0/01", HREADYOUTS, HRESPS); end
        checks++;
        if (HRDATAS !== 32'd0 || HRUSERS !== 32'd0) begin errors++; $display("FAIL unm_data: got %h/%h want 0/0", HRDATAS, HRUSERS); end
        trans_dec = 2'b00; HREADYS = 1'b0;
        tick();
        checks++;
        if (HREADYOUTS !== 1'b1 || HRESPS !== 2'b01) begin errors++; $display("FAIL unm_err2: got %b/%b want 1/01", HREADYOUTS, HRESPS); end
        checks++;
        if (err_count !== exp_cnt || err_addr !== 22'h080000) begin errors++; $display("FAIL unm_log: got %0d/%h want %0d/080000", err_count, err_addr, exp_cnt); end
        HREADYS = 1'b1;
        tick();
        checks++;
        if (HREADYOUTS !== 1'b1 || HRESPS !== 2'b00) begin errors++; $display("FAIL unm_idle_okay: got %b/%b want 1/00", HREADYOUTS, HRESPS); end
        $display("test_unmapped count %0d addr %h", err_count, err_addr);
    endtask

    task automatic test_back_to_back();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        exp_cnt = 16'd0;
        checks++;
        if (err_count !== 16'd0 || err_addr !== 22'd0) begin errors++; $display("FAIL b2b_clr: got %0d/%h want 0/0", err_count, err_addr); end
        for (int pass = 0; pass < 2; pass++) begin
            do_unmapped(22'h080000);
            exp_cnt = exp_cnt + 16'd1;
            // second trigger issued while in ERR2
            trans_dec = 2'b10; decode_addr_dec = 22'h080001; err_clr = (pass == 1);
            tick();
            exp_cnt = (pass == 1) ? 16'd1 : exp_cnt + 16'd1;
            err_clr = 1'b0; trans_dec = 2'b00; HREADYS = 1'b0;
            checks++;
            if (HREADYOUTS !== 1'b0 || HRESPS !== 2'b01) begin errors++; $display("FAIL b2b_err1_%0d: got %b/%b want 0/01", pass, HREADYOUTS, HRESPS); end
            checks++;
            if (err_count !== exp_cnt || err_addr !== 22'h080001) begin errors++; $display("FAIL b2b_log%0d: got %0d/%h want %0d/080001", pass, err_count, err_addr, exp_cnt); end
            tick();
            HREADYS = 1'b1;
            tick();
            $display("test_back_to_back pass %0d count %0d", pass, err_count);
        end
    endtask

    task automatic test_remap();
        sel_dec = 1'b1; trans_dec = 2'b10; HREADYS = 1'b1; decode_addr_dec = 22'h000001; remap = 1'b1;
        #1;
        checks++;
        if (sel_out !== 3'b010) begin errors++; $display("FAIL remap_on: got %b want 010", sel_out); end
        remap = 1'b0;
        #1;
        checks++;
        if (sel_out !== 3'b001) begin errors++; $display("FAIL remap_off: got %b want 001", sel_out); end
        tick();
        $display("test_remap done");
    endtask

    task automatic test_hold_stall();
        sel_dec = 1'b1; trans_dec = 2'b10; HREADYS = 1'b1; decode_addr_dec = 22'h04003F;
        tick();
        readyout_in = 3'b101; HREADYS = 1'b0; trans_dec = 2'b00; decode_addr_dec = 22'h080000;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (sel_out !== 3'b010 || HREADYOUTS !== 1'b0) begin errors++; $display("FAIL hold_stall%0d: got sel %b rdy %b want 010/0", c, sel_out, HREADYOUTS); end
            tick();
        end
        readyout_in = 3'b111;
        #1;
        checks++;
        if (HREADYOUTS !== 1'b1 || sel_out !== 3'b010) begin errors++; $display("FAIL hold_release: got rdy %b sel %b want 1/010", HREADYOUTS, sel_out); end
        HREADYS = 1'b1;
        tick();
        checks++;
        if (err_count !== exp_cnt || HRDATAS !== 32'hA000_0001) begin errors++; $display("FAIL hold_after: got %0d/%h want %0d/a0000001", err_count, HRDATAS, exp_cnt); end
        $display("test_hold_stall done");
    endtask

    task automatic test_reset_mid_error();
        sel_dec = 1'b1; trans_dec = 2'b10; HREADYS = 1'b1; decode_addr_dec = 22'h080000;
        tick();
        trans_dec = 2'b00; HREADYS = 1'b0;
        checks++;
        if (HREADYOUTS !== 1'b0) begin errors++; $display("FAIL rst_mid_pre: got %b want 0", HREADYOUTS); end
        HRESETn = 1'b0;
        #1;
        checks++;
        if (HREADYOUTS !== 1'b1 || HRESPS !== 2'b00 || err_count !== 16'd0) begin
            errors++; $display("FAIL rst_mid: got %b/%b cnt %0d want 1/00 cnt 0", HREADYOUTS, HRESPS, err_count);
        end
        tick();
        HRESETn = 1'b1; HREADYS = 1'b1;
        tick();
        exp_cnt = 16'd0;
        $display("test_reset_mid_error done");
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 4; n++) do_unmapped(22'h080002 + 22'(n));
        trans_dec = 2'b00;
        tick();
        checks++;
        if (err_count !== 16'd4) begin errors++; $display("FAIL sat_wide: got %0d want 4", err_count); end
        checks++;
        if (err_count_s !== 2'd3 || err_addr_s !== 22'h080005) begin errors++; $display("FAIL sat_narrow: got %0d/%h want 3/080005", err_count_s, err_addr_s); end
        $display("test_saturation counts %0d/%0d", err_count, err_count_s);
    endtask

    initial begin
        test_reset();
        test_map();
        test_unmapped();
        test_back_to_back();
        test_remap();
        test_hold_stall();
        test_reset_mid_error();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
